// File: rtl/mem_arbiter_pkg.sv
// Shared types for the RAM-port arbiter, request unit and caches.
package mem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IACC = 2'd1,
      DACC = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side bus of the arbiter; slave = arbiter, master = requesters plus RAM.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic  iren;
   addr_t iaddr;
   logic  ihit;
   data_t iload;
   logic  dren;
   logic  dwen;
   addr_t daddr;
   data_t dstore;
   logic  dhit;
   data_t dload;
   logic  ram_ren;
   logic  ram_wen;
   addr_t ram_addr;
   data_t ram_store;
   data_t ram_load;
   logic  ram_ready;
   logic  err;

   modport slave (
      input  iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
      output ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, err
   );

   modport master (
      output iren, iaddr, dren, dwen, daddr, dstore, ram_load, ram_ready,
      input  ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store, err
   );

endinterface

// File: rtl/mem_arbiter_timeout.sv
// Access-duration counter: cleared outside an access, flags the last permitted cycle.
module mem_arb_timeout #(
   parameter int TIMEOUT = 64
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] timer;

   always_ff @(posedge CLK) begin
      if (RST)
         timer <= '0;
      else if (clr)
         timer <= '0;
      else if (en)
         timer <= timer + CW'(1);
   end

   assign expire = (timer == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data requesters.
//  state | meaning
//  IDLE  | no access in flight; arbitrate and latch the winner's command
//  IACC  | instruction read in flight, waiting for ram_ready
//  DACC  | data read/write in flight, waiting for ram_ready
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 64
) (
   input logic         CLK,
   input logic         RST,
   mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(MAX_DSTREAK + 1);
   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_IACC = IACC;
   localparam logic [1:0] S_DACC = DACC;

   logic [1:0]    state, state_nx;
   logic [SW-1:0] streak;
   addr_t         addr_q;
   data_t         store_q;
   logic          wr_q;
   logic          d_req, i_starved, grant_d, grant_i, in_acc, expire, abort;

   assign d_req     = bus.dren | bus.dwen;
   assign i_starved = bus.iren & (streak == SW'(MAX_DSTREAK));
   assign grant_d   = (state == S_IDLE) & d_req & ~i_starved;
   assign grant_i   = (state == S_IDLE) & ~grant_d & bus.iren;
   assign in_acc    = (state == S_IACC) | (state == S_DACC);
   assign abort     = in_acc & ~bus.ram_ready & expire;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (grant_d)
               state_nx = S_DACC;
            else if (grant_i)
               state_nx = S_IACC;
         end
         S_IACC, S_DACC: begin
            if (bus.ram_ready | expire)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         streak  <= '0;
         addr_q  <= '0;
         store_q <= '0;
         wr_q    <= 1'b0;
      end else begin
         state <= state_nx;
         if (grant_d) begin
            addr_q  <= bus.daddr;
            store_q <= bus.dstore;
            wr_q    <= bus.dwen;
            // streak only matters while an instruction fetch is being held off
            if (!bus.iren)
               streak <= '0;
            else if (streak != SW'(MAX_DSTREAK))
               streak <= streak + SW'(1);
         end else if (grant_i) begin
            addr_q  <= bus.iaddr;
            store_q <= '0;
            wr_q    <= 1'b0;
            streak  <= '0;
         end
      end
   end

   mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .CLK    (CLK),
      .RST    (RST),
      .clr    (~in_acc),
      .en     (in_acc & ~bus.ram_ready & ~expire),
      .expire (expire)
   );

   assign bus.ram_ren   = (state == S_IACC) | ((state == S_DACC) & ~wr_q);
   assign bus.ram_wen   = (state == S_DACC) & wr_q;
   assign bus.ram_addr  = in_acc ? addr_q : '0;
   assign bus.ram_store = ((state == S_DACC) & wr_q) ? store_q : '0;

   assign bus.ihit  = (state == S_IACC) & bus.ram_ready;
   assign bus.dhit  = (state == S_DACC) & bus.ram_ready;
   assign bus.iload = bus.ihit ? bus.ram_load : '0;
   assign bus.dload = bus.dhit ? bus.ram_load : '0;
   assign bus.err   = abort;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_mem_arbiter;
   localparam int MAXS = 4;
   localparam int TMO  = 64;

   logic CLK;
   logic RST;
   int   n_checks = 0;
   int   n_err    = 0;

   mem_arbiter_if bus ();

   mem_arbiter #(.MAX_DSTREAK(MAXS), .TIMEOUT(TMO)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // transaction model: who owns the port, what was latched, how long it has waited
   bit          m_busy, m_is_d, m_wr;
   logic [31:0] m_addr, m_store;
   int          m_age, m_streak;
   logic        e_ihit, e_dhit, e_ren, e_wen, e_err;
   logic [31:0] e_iload, e_dload, e_addr, e_store;
   logic        o_ihit, o_dhit, o_ren, o_wen, o_err;
   logic [31:0] o_iload, o_dload, o_addr, o_store;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      e_ihit = 0; e_dhit = 0; e_ren = 0; e_wen = 0; e_err = 0;
      e_iload = '0; e_dload = '0; e_addr = '0; e_store = '0;
      if (RST) begin
         m_busy = 0; m_streak = 0;
         return;
      end
      if (!m_busy) begin
         if ((bus.dren || bus.dwen) && !(bus.iren && m_streak >= MAXS)) begin
            m_busy = 1; m_is_d = 1; m_wr = bus.dwen; m_addr = bus.daddr;
            m_store = bus.dstore; m_age = 0;
            m_streak = bus.iren ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
         end else if (bus.iren) begin
            m_busy = 1; m_is_d = 0; m_wr = 0; m_addr = bus.iaddr; m_age = 0;
            m_streak = 0;
         end
      end else begin
         e_ren   = !m_wr;
         e_wen   = m_wr;
         e_addr  = m_addr;
         e_store = m_wr ? m_store : 32'h0;
         if (bus.ram_ready) begin
            if (m_is_d) begin e_dhit = 1; e_dload = bus.ram_load; end
            else        begin e_ihit = 1; e_iload = bus.ram_load; end
            m_busy = 0;
         end else if (m_age == TMO - 1) begin
            e_err = 1; m_busy = 0;
         end else begin
            m_age++;
         end
      end
   endtask

   task automatic cycle(input bit chk);
      #3;
      o_ihit = bus.ihit; o_dhit = bus.dhit; o_ren = bus.ram_ren; o_wen = bus.ram_wen;
      o_err = bus.err; o_iload = bus.iload; o_dload = bus.dload;
      o_addr = bus.ram_addr; o_store = bus.ram_store;
      model_step();
      if (chk && !RST) begin
         check_eq("ihit", 32'(o_ihit), 32'(e_ihit));
         check_eq("dhit", 32'(o_dhit), 32'(e_dhit));
         check_eq("iload", o_iload, e_iload);
         check_eq("dload", o_dload, e_dload);
         check_eq("ram_ren", 32'(o_ren), 32'(e_ren));
         check_eq("ram_wen", 32'(o_wen), 32'(e_wen));
         check_eq("ram_addr", o_addr, e_addr);
         check_eq("ram_store", o_store, e_store);
         check_eq("err", 32'(o_err), 32'(e_err));
         check_eq("hit_excl", 32'(o_ihit & o_dhit), 32'h0);
         check_eq("strobe_excl", 32'(o_ren & o_wen), 32'h0);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.iren = 0; bus.dren = 0; bus.dwen = 0; bus.ram_ready = 0;
      bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ram_load = '0;
   endtask

   initial begin
      int nd, n, hang;
      bit got_i, seen_err;
      bit ip, dp;

      RST = 1;
      idle_inputs();
      m_busy = 0; m_streak = 0; m_age = 0; m_is_d = 0; m_wr = 0;
      m_addr = '0; m_store = '0;
      cycle(0);
      cycle(0);
      RST = 0;
      cycle(1);
      check_eq("rst_ren", 32'(o_ren), 32'h0);
      check_eq("rst_addr", o_addr, 32'h0);

      // instruction fetch only, ready on the third access cycle
      bus.iren = 1; bus.iaddr = 32'h100;
      cycle(1);
      for (int k = 0; k < 3; k++) begin
         bus.ram_ready = (k == 2); bus.ram_load = 32'h1234_5678;
         cycle(1);
         if (k == 0) begin
            check_eq("b_ren", 32'(o_ren), 32'h1);
            check_eq("b_addr", o_addr, 32'h100);
         end
         check_eq("b_ihit", 32'(o_ihit), 32'(k == 2));
      end
      check_eq("b_iload", o_iload, 32'h1234_5678);
      bus.iren = 0; bus.ram_ready = 0;
      cycle(1);
      check_eq("b_after", 32'(o_ihit), 32'h0);

      // simultaneous requests: data first, idle gap, then instruction
      bus.iren = 1; bus.iaddr = 32'h300; bus.dren = 1; bus.daddr = 32'h200;
      bus.ram_ready = 1; bus.ram_load = 32'hCAFE_0001;
      for (int k = 0; k < 4; k++) begin
         cycle(1);
         case (k)
            0: check_eq("c_idle0_ren", 32'(o_ren), 32'h0);
            1: begin check_eq("c_dhit", 32'(o_dhit), 32'h1); check_eq("c_daddr", o_addr, 32'h200); end
            2: check_eq("c_gap", 32'({o_ren, o_ihit, o_dhit}), 32'h0);
            default: begin check_eq("c_ihit", 32'(o_ihit), 32'h1); check_eq("c_iaddr", o_addr, 32'h300); end
         endcase
         if (o_dhit) bus.dren = 0;
         if (o_ihit) bus.iren = 0;
      end

      // data hogging the port: instruction gets in after MAX_DSTREAK grants
      bus.iren = 1; bus.iaddr = 32'h500; bus.dren = 1; bus.daddr = 32'h10;
      bus.ram_ready = 1;
      nd = 0; got_i = 0;
      for (int k = 0; k < 40 && !got_i; k++) begin
         bus.ram_load = $urandom;
         cycle(1);
         if (o_dhit) begin nd++; bus.daddr = $urandom; end
         if (o_ihit) got_i = 1;
      end
      check_eq("streak_dhits", nd, MAXS);
      check_eq("streak_ihit", 32'(got_i), 32'h1);
      bus.iren = 0;
      nd = 0;
      for (int k = 0; k < 4; k++) begin
         cycle(1);
         if (o_dhit) nd++;
      end
      check_eq("streak_resume", nd, 2);
      bus.dren = 0; bus.ram_ready = 0;
      cycle(1);

      // read+write together is a write
      bus.dren = 1; bus.dwen = 1; bus.daddr = 32'h40; bus.dstore = 32'hDEAD_BEEF;
      cycle(1);
      bus.ram_ready = 1;
      cycle(1);
      check_eq("w_wen", 32'(o_wen), 32'h1);
      check_eq("w_ren", 32'(o_ren), 32'h0);
      check_eq("w_store", o_store, 32'hDEAD_BEEF);
      check_eq("w_dhit", 32'(o_dhit), 32'h1);
      bus.dren = 0; bus.dwen = 0; bus.ram_ready = 0;
      cycle(1);

      // hung RAM: abort after TIMEOUT access cycles
      bus.dren = 1; bus.daddr = 32'h80;
      cycle(1);
      n = 0; nd = 0; seen_err = 0;
      for (int k = 0; k < 100 && !seen_err; k++) begin
         cycle(1);
         n++;
         if (o_dhit) nd++;
         if (o_err) seen_err = 1;
      end
      check_eq("to_cycles", n, TMO);
      check_eq("to_seen", 32'(seen_err), 32'h1);
      check_eq("to_nohit", nd, 0);
      bus.dren = 0;
      cycle(1);
      check_eq("to_idle", 32'(o_ren), 32'h0);

      // reset in the middle of an instruction access
      bus.iren = 1; bus.iaddr = 32'h700;
      cycle(1);
      cycle(1);
      check_eq("r_inacc", 32'(o_ren), 32'h1);
      RST = 1;
      cycle(0);
      RST = 0; bus.iren = 0; bus.ram_ready = 1;
      cycle(1);
      check_eq("r_noihit", 32'(o_ihit), 32'h0);
      check_eq("r_ren", 32'(o_ren), 32'h0);
      bus.ram_ready = 0;
      cycle(1);

      // random traffic against the model
      hang = 0; ip = 0; dp = 0;
      for (int k = 0; k < 4000; k++) begin
         if (!ip && $urandom_range(3) == 0) begin
            ip = 1; bus.iren = 1; bus.iaddr = $urandom;
         end
         if (!dp && $urandom_range(2) == 0) begin
            dp = 1;
            case ($urandom_range(2))
               0: begin bus.dren = 1; bus.dwen = 0; end
               1: begin bus.dren = 0; bus.dwen = 1; end
               default: begin bus.dren = 1; bus.dwen = 1; end
            endcase
            bus.daddr = $urandom; bus.dstore = $urandom;
         end
         if (hang == 0 && $urandom_range(299) == 0) hang = 70;
         if (hang > 0) begin
            hang--; bus.ram_ready = 0;
         end else begin
            bus.ram_ready = ($urandom_range(2) == 0);
         end
         bus.ram_load = $urandom;
         cycle(1);
         if (e_ihit) begin ip = 0; bus.iren = 0; end
         if (e_dhit) begin dp = 0; bus.dren = 0; bus.dwen = 0; end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
